// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM capture path.
// Provides the measurement FSM state and parameter defaults.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE
    } pwm_meas_state_t;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/pwm_measure_if.sv
// Bus between the PWM generator side and the capture stage.
// master: drives en/pwm_in/exp_*; slave: drives the measurement results.
interface pwm_measure_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             en;
    logic             pwm_in;
    logic [7:0]       exp_period;
    logic [7:0]       exp_high;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             valid_o;
    logic             mismatch_o;
    logic             ovf_o;
    logic             stuck_o;
    logic             stuck_lvl_o;

    modport master (
        output en, pwm_in, exp_period, exp_high,
        input  period_o, high_o, valid_o,
        input  mismatch_o, ovf_o, stuck_o, stuck_lvl_o
    );

    modport slave (
        input  en, pwm_in, exp_period, exp_high,
        output period_o, high_o, valid_o,
        output mismatch_o, ovf_o, stuck_o, stuck_lvl_o
    );

endinterface

// File: rtl/pwm_sat_counter.sv
// Saturating up-counter with clear and load (clear wins over load).
// Ports: clk, reset (sync, active-low), clr_i, load_i, load_val_i, inc_i, cnt_o, sat_o.
module pwm_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat_o = (cnt_q == '1);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_measure.sv
// PWM capture: measures period/high time rise-to-rise, checks vs expected.
// Ports: clk, reset (sync, active-low), bus (pwm_measure_if.slave).
module pwm_measure
    import pwm_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    pwm_measure_if.slave   bus
);

    localparam int XW = (CNT_W > 8) ? CNT_W : 8;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    // Last count before the counter would reach TIMEOUT.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    pwm_meas_state_t  state_q, state_d;
    logic             pwm_dly_q;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             mism_q, mism_d;
    logic             ovf_q, ovf_d;
    logic             stuck_q, stuck_d;
    logic             lvl_q, lvl_d;

    logic             rise;
    logic             cnt_clr, cnt_load;
    logic             p_inc, h_inc;
    logic [CNT_W-1:0] p_cnt, h_cnt;
    logic             p_sat, h_sat;

    assign rise = bus.pwm_in & ~pwm_dly_q;

    pwm_sat_counter #(.W(CNT_W)) u_period (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (ONE),
        .inc_i      (p_inc),
        .cnt_o      (p_cnt),
        .sat_o      (p_sat)
    );

    pwm_sat_counter #(.W(CNT_W)) u_high (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (ONE),
        .inc_i      (h_inc),
        .cnt_o      (h_cnt),
        .sat_o      (h_sat)
    );

    always_comb begin
        state_d  = state_q;
        sat_d    = sat_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        mism_d   = mism_q;
        ovf_d    = ovf_q;
        stuck_d  = stuck_q;
        lvl_d    = lvl_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        p_inc    = 1'b0;
        h_inc    = 1'b0;
        // Dropping en beats a same-cycle rise or timeout.
        if (!bus.en) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
            sat_d   = 1'b0;
            stuck_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                    sat_d   = 1'b0;
                    state_d = ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        cnt_load = 1'b1;
                        sat_d    = 1'b0;
                        state_d  = MEASURE;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = p_cnt;
                        high_d   = h_cnt;
                        ovf_d    = sat_q;
                        mism_d   = (XW'(p_cnt) != XW'(bus.exp_period))
                                 | (XW'(h_cnt) != XW'(bus.exp_high));
                        valid_d  = 1'b1;
                        cnt_load = 1'b1;
                        sat_d    = 1'b0;
                        stuck_d  = 1'b0;
                    end else if (p_cnt == TO_LAST) begin
                        stuck_d = 1'b1;
                        lvl_d   = bus.pwm_in;
                        cnt_clr = 1'b1;
                        state_d = ARMED;
                    end else begin
                        p_inc = 1'b1;
                        h_inc = bus.pwm_in;
                        sat_d = sat_q | p_sat | (bus.pwm_in & h_sat);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            pwm_dly_q <= 1'b0;
            sat_q     <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            mism_q    <= 1'b0;
            ovf_q     <= 1'b0;
            stuck_q   <= 1'b0;
            lvl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwm_dly_q <= bus.pwm_in;
            sat_q     <= sat_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            mism_q    <= mism_d;
            ovf_q     <= ovf_d;
            stuck_q   <= stuck_d;
            lvl_q     <= lvl_d;
        end
    end

    assign bus.period_o    = period_q;
    assign bus.high_o      = high_q;
    assign bus.valid_o     = valid_q;
    assign bus.mismatch_o  = mism_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.stuck_o     = stuck_q;
    assign bus.stuck_lvl_o = lvl_q;

endmodule

// File: tb/tb_pwm_measure.sv
// Directed scoreboard bench for pwm_measure.
// DUT0: CNT_W=16, TIMEOUT=16; DUT1: CNT_W=4, TIMEOUT=15.
module tb_pwm_measure;

    typedef struct {
        int   cyc;
        int   per;
        int   hi;
        logic mm;
        logic ov;
    } exp_t;

    logic clk;
    logic reset;
    int   cycle;
    int   checks;
    int   errors;
    exp_t q0[$];
    exp_t q1[$];

    pwm_measure_if #(.CNT_W(16)) b0();
    pwm_measure_if #(.CNT_W(4))  b1();

    pwm_measure #(.CNT_W(16), .TIMEOUT(16)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    pwm_measure #(.CNT_W(4), .TIMEOUT(15)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mon(int d, logic v, logic [15:0] p, logic [15:0] h,
                       logic mm, logic ov);
        exp_t e;
        if (v) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                chk($sformatf("d%0d_unexpected_valid", d), 1, 0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("d%0d_valid_cycle", d), cycle, e.cyc);
                chk($sformatf("d%0d_period", d), p, e.per);
                chk($sformatf("d%0d_high", d), h, e.hi);
                chk($sformatf("d%0d_mismatch", d), mm, e.mm);
                chk($sformatf("d%0d_ovf", d), ov, e.ov);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cycle++;
        mon(0, b0.valid_o, b0.period_o, b0.high_o,
            b0.mismatch_o, b0.ovf_o);
        mon(1, b1.valid_o, 16'(b1.period_o), 16'(b1.high_o),
            b1.mismatch_o, b1.ovf_o);
    endtask

    task automatic drv(int d, logic v);
        if (d == 0) b0.pwm_in = v;
        else        b1.pwm_in = v;
    endtask

    task automatic push(int d, int p, int h, int ep, int eh);
        exp_t e;
        e.cyc = cycle + 1;
        e.per = p;
        e.hi  = h;
        e.mm  = (p != ep) || (h != eh);
        e.ov  = 1'b0;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic set_exp(int d, int ep, int eh);
        if (d == 0) begin
            b0.exp_period = 8'(ep);
            b0.exp_high   = 8'(eh);
        end else begin
            b1.exp_period = 8'(ep);
            b1.exp_high   = 8'(eh);
        end
    endtask

    task automatic run_wave(int d, int p, int h, int n, int ep, int eh,
                            bit pf, int fp, int fh);
        set_exp(d, ep, eh);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                drv(d, i < h);
                if (i == 0 && k > 0) push(d, p, h, ep, eh);
                else if (i == 0 && pf) push(d, fp, fh, ep, eh);
                cyc();
            end
        end
    endtask

    task automatic qempty(string tag);
        chk({tag, "_q0_left"}, q0.size(), 0);
        chk({tag, "_q1_left"}, q1.size(), 0);
    endtask

    task automatic zeros(string t, logic [15:0] p, logic [15:0] h,
                         logic v, logic m, logic o, logic s, logic l);
        chk({t, "_period"}, p, 0);
        chk({t, "_high"}, h, 0);
        chk({t, "_valid"}, v, 0);
        chk({t, "_mismatch"}, m, 0);
        chk({t, "_ovf"}, o, 0);
        chk({t, "_stuck"}, s, 0);
        chk({t, "_lvl"}, l, 0);
    endtask

    initial begin
        cycle  = 0;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        b0.en = 1'b0; b0.pwm_in = 1'b0;
        b1.en = 1'b0; b1.pwm_in = 1'b0;
        set_exp(0, 10, 3);
        set_exp(1, 14, 5);
        repeat (3) cyc();
        zeros("rst0", b0.period_o, b0.high_o, b0.valid_o,
              b0.mismatch_o, b0.ovf_o, b0.stuck_o, b0.stuck_lvl_o);
        zeros("rst1", 16'(b1.period_o), 16'(b1.high_o), b1.valid_o,
              b1.mismatch_o, b1.ovf_o, b1.stuck_o, b1.stuck_lvl_o);
        reset = 1'b1;

        // Matching waveform P=10 H=3.
        b0.en = 1'b1;
        repeat (3) cyc();
        run_wave(0, 10, 3, 4, 10, 3, 1'b0, 0, 0);
        qempty("match");
        chk("match_hold_period", b0.period_o, 10);

        // Expected high differs.
        run_wave(0, 10, 3, 3, 10, 4, 1'b1, 10, 3);
        qempty("mism");
        chk("mism_hold_high", b0.high_o, 3);

        // Constant high after a rise: timeout at 16.
        set_exp(0, 10, 3);
        for (int i = 0; i < 20; i++) begin
            drv(0, 1'b1);
            if (i == 0) push(0, 10, 3, 10, 3);
            cyc();
            if (i == 14) chk("stuck_early", b0.stuck_o, 0);
            if (i == 15) begin
                chk("stuck_set", b0.stuck_o, 1);
                chk("stuck_lvl_hi", b0.stuck_lvl_o, 1);
            end
        end
        drv(0, 1'b0);
        cyc();
        chk("stuck_hold", b0.stuck_o, 1);
        run_wave(0, 10, 3, 2, 10, 3, 1'b0, 0, 0);
        chk("stuck_cleared", b0.stuck_o, 0);
        qempty("stuck");

        // Reset mid-period (cycle 5 of 10).
        run_wave(0, 10, 3, 2, 10, 3, 1'b1, 10, 3);
        for (int i = 0; i < 5; i++) begin
            drv(0, i < 3);
            if (i == 0) push(0, 10, 3, 10, 3);
            cyc();
        end
        reset = 1'b0;
        drv(0, 1'b0);
        cyc();
        zeros("midrst", b0.period_o, b0.high_o, b0.valid_o,
              b0.mismatch_o, b0.ovf_o, b0.stuck_o, b0.stuck_lvl_o);
        reset = 1'b1;
        repeat (4) cyc();
        run_wave(0, 10, 3, 3, 10, 3, 1'b0, 0, 0);
        qempty("midrst");
        chk("midrst_period", b0.period_o, 10);

        // en dropped in the rise cycle.
        b0.en = 1'b0;
        drv(0, 1'b1);
        cyc();
        chk("endrop_valid", b0.valid_o, 0);
        chk("endrop_period", b0.period_o, 10);
        b0.en = 1'b1;
        for (int i = 1; i < 10; i++) begin
            drv(0, i < 3);
            cyc();
        end
        run_wave(0, 10, 3, 3, 10, 3, 1'b0, 0, 0);
        qempty("endrop");
        b0.en = 1'b0;
        drv(0, 1'b0);

        // Narrow counters: P=14 fits, P=20 times out.
        b1.en = 1'b1;
        repeat (3) cyc();
        run_wave(1, 14, 5, 3, 14, 5, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drv(1, i < 5);
            if (i == 0) push(1, 14, 5, 14, 5);
            cyc();
            if (i == 13) chk("n_stuck_early", b1.stuck_o, 0);
            if (i == 14) begin
                chk("n_stuck_set", b1.stuck_o, 1);
                chk("n_stuck_lvl_lo", b1.stuck_lvl_o, 0);
            end
        end
        drv(1, 1'b1);
        cyc();
        chk("n_stuck_hold", b1.stuck_o, 1);
        chk("n_period_hold", 16'(b1.period_o), 14);
        qempty("narrow");

        // Back-to-back rises P=2 H=1.
        b0.en = 1'b1;
        repeat (3) cyc();
        run_wave(0, 2, 1, 6, 2, 1, 1'b0, 0, 0);
        qempty("b2b");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_measure.md
# pwm_measure

Cycle-accurate PWM capture stage sitting directly downstream of the PWM generator. Samples the generator's `io_out` in the same clock domain and measures each complete period (rising edge to rising edge) and its high time. Compares the measurements against the period and duty values programmed into the generator, and flags stuck or overflowing waveforms. Used as the self-check and telemetry stage for the PWM path.

## Interface
- `CNT_W`, 16: width of the period and high-time counters and outputs.
- `TIMEOUT`, 1024: cycles without a rising edge before `stuck_o` asserts. Must be in the range 2..2^CNT_W-1.
- `clk` input 1: clock; all logic is on the rising edge.
- `reset` input 1: reset, synchronous, active-low. Clock is `clk`.
- `en` input 1: measurement enable.
- `pwm_in` input 1: PWM waveform, synchronous to `clk`; no synchronizer.
- `exp_period` input 8: expected period in cycles, i.e. the generator's programmed period.
- `exp_high` input 8: expected high cycles, i.e. the generator's programmed duty.
- `period_o` output CNT_W: last measured period in cycles.
- `high_o` output CNT_W: last measured high time in cycles.
- `valid_o` output 1: one-cycle pulse when `period_o`/`high_o` update.
- `mismatch_o` output 1: qualified by `valid_o`; measurement differs from expected.
- `ovf_o` output 1: qualified by `valid_o`; a counter saturated during the period.
- `stuck_o` output 1: level; no rising edge for `TIMEOUT` cycles.
- `stuck_lvl_o` output 1: `pwm_in` level when `stuck_o` asserted.

## Operation
- `pwm_d` is a registered copy of `pwm_in`, reset to 0. A rising edge is `rise = pwm_in & ~pwm_d`.
- **IDLE:** entered on reset or when `en` = 0.
  - Counters clear.
  - `valid_o` = 0.
  - `period_o`/`high_o` hold their values.
  - `stuck_o` clears.
- **ARMED:** entered from IDLE when `en` = 1.
  - Waits for `rise`, then loads `period_cnt` = 1 and `high_cnt` = 1, and moves to MEASURE.
  - No output is produced from the first edge.
- **MEASURE:**
  - On each non-rise cycle: `period_cnt` += 1 and `high_cnt` += `pwm_in`, both saturating at 2^CNT_W-1. The sticky `sat` flag sets if either counter would exceed the maximum.
  - On `rise`:
    - `period_o` ← `period_cnt` and `high_o` ← `high_cnt`.
    - `ovf_o` ← `sat`.
    - `mismatch_o` ← (`period_cnt` ≠ zero-extended `exp_period`) | (`high_cnt` ≠ zero-extended `exp_high`), using `exp_*` sampled in the rise cycle.
    - `valid_o` ← 1.
    - Counters reload to 1,1 and `sat` clears.
    - `stuck_o` clears.
  - When `period_cnt` reaches `TIMEOUT` without a rise:
    - `stuck_o` ← 1 and `stuck_lvl_o` ← `pwm_in`.
    - Move to ARMED. `period_o`/`high_o` are not updated.
- `en` falling takes priority over `rise` and timeout in the same cycle: go to IDLE and do not pulse `valid_o`.
- `reset` has priority over everything, including mid-period. All outputs go to 0 and the state goes to IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0.
- For a waveform with period P and high H, where the rise occurs in cycle t:
  - `period_o` = P, `high_o` = H, and `valid_o` = 1 are visible in cycle t+1.
  - `valid_o` lasts exactly 1 cycle.
- The first valid measurement appears 1 cycle after the second rising edge following `en` = 1.
- `stuck_o` rises exactly `TIMEOUT` cycles after the last rise, counting the rise cycle as 1. It stays high until the next `valid_o`, `en` = 0, or reset.
- Constant-high input: `high_cnt` tracks `period_cnt`, then timeout fires with `stuck_lvl_o` = 1.
- Back-to-back rises (P = 2, H = 1) are supported: `valid_o` pulses every 2 cycles.

## Structure
- Shared package `pwm_pkg`:
  - state enum `pwm_meas_state_t` {IDLE, ARMED, MEASURE};
  - default `CNT_W`;
  - the `TIMEOUT` localparam default.
- One sub-module, `pwm_sat_counter`:
  - parameter `W`;
  - inputs: clear, load value, increment enable;
  - outputs: count and a saturated flag.
- Instantiated twice, once for period and once for high time.
- Edge detect and FSM live in the top module.

## Test plan
- `exp_period` = 10, `exp_high` = 3, `pwm_in` periodic with P = 10, H = 3 → `valid_o` every 10 cycles from the second rise, `period_o` = 10, `high_o` = 3, `mismatch_o` = 0.
- Same waveform but `exp_high` = 4 → `valid_o` with `mismatch_o` = 1 and `high_o` = 3.
- `pwm_in` held at 1 after one rise, `TIMEOUT` = 16 → `stuck_o` = 1 at cycle 16 after the rise, `stuck_lvl_o` = 1, no `valid_o`. A later valid period clears `stuck_o`.
- `CNT_W` = 4, `TIMEOUT` = 15, period 20 → no `valid_o`, `stuck_o` asserts. With `TIMEOUT` = 15 and P = 14 → `ovf_o` = 0, `period_o` = 14.
- Reset driven low mid-period (cycle 5 of 10) → all outputs 0 next cycle. After release, the first `valid_o` comes only after two rises.
- `en` dropped in the same cycle as a rise → no `valid_o`, state IDLE, `period_o` holds its previous value.
